// File: rtl/ex_muldiv_pkg.sv
// Shared FUNCT codes, widths and FSM state type for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CNT_W_DEF = 6;
  localparam int unsigned FUNCT_W   = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic is_signed_funct(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/ex_div_core.sv
// Restoring divider datapath on magnitudes: one quotient bit per step.
module ex_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH-1:0] rem_q, quot_q, dvsr_q;
  logic [WIDTH:0]   trial_c, diff_c;

  // Partial remainder shifted left with the next dividend bit; bit WIDTH of diff flags a borrow.
  assign trial_c = {rem_q, quot_q[WIDTH-1]};
  assign diff_c  = trial_c - {1'b0, dvsr_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
    end else if (start_i) begin
      rem_q  <= '0;
      quot_q <= dividend_i;
      dvsr_q <= divisor_i;
    end else if (step_i) begin
      if (!diff_c[WIDTH]) begin
        rem_q  <= diff_c[WIDTH-1:0];
        quot_q <= {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q  <= trial_c[WIDTH-1:0];
        quot_q <= {quot_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit owning architectural HI/LO; stalls the pipe while busy.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   operand_1,
  input  logic [WIDTH-1:0]   operand_2,
  input  logic               flush,
  output logic               stall_req,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int unsigned PW = 2 * WIDTH;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             mul_q, dz_q, sign1_q, sign2_q;
  logic [WIDTH-1:0] mcand_q;
  logic [PW-1:0]    prod_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             start_mul, start_div, step, done, mt_hi, mt_lo;
  logic             sign1_c, sign2_c;
  logic [WIDTH-1:0] abs1_c, abs2_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [PW-1:0]    prod_fix_c;
  logic [WIDTH-1:0] quot_c, rem_c, quot_fix_c, rem_fix_c;

  // Signed ops iterate on magnitudes; signs are re-applied when the result is committed.
  assign sign1_c = is_signed_funct(funct) & operand_1[WIDTH-1];
  assign sign2_c = is_signed_funct(funct) & operand_2[WIDTH-1];
  assign abs1_c  = sign1_c ? (~operand_1 + WIDTH'(1)) : operand_1;
  assign abs2_c  = sign2_c ? (~operand_2 + WIDTH'(1)) : operand_2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    stall_req = 1'b0;
    result    = '0;
    start_mul = 1'b0;
    start_div = 1'b0;
    step      = 1'b0;
    done      = 1'b0;
    mt_hi     = 1'b0;
    mt_lo     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          case (funct)
            FUNCT_MULT, FUNCT_MULTU: begin
              start_mul = 1'b1;
              stall_req = 1'b1;
              state_d   = ST_MUL;
            end
            FUNCT_DIV, FUNCT_DIVU: begin
              start_div = 1'b1;
              stall_req = 1'b1;
              state_d   = (operand_2 == '0) ? ST_DONE : ST_DIV;
            end
            FUNCT_MTHI: mt_hi  = 1'b1;
            FUNCT_MTLO: mt_lo  = 1'b1;
            FUNCT_MFHI: result = hi_q;
            FUNCT_MFLO: result = lo_q;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        stall_req = 1'b1;
        step      = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
    // Flush aborts everything: no start, no commit, no HI/LO write, no stall.
    if (flush) begin
      state_d   = ST_IDLE;
      stall_req = 1'b0;
      start_mul = 1'b0;
      start_div = 1'b0;
      step      = 1'b0;
      done      = 1'b0;
      mt_hi     = 1'b0;
      mt_lo     = 1'b0;
    end
  end

  // Shift-add step: conditionally add multiplicand into the upper half, then shift right.
  assign mul_sum_c = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      dz_q    <= 1'b0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (start_mul || start_div) begin
      cnt_q   <= '0;
      mul_q   <= start_mul;
      dz_q    <= start_div && (operand_2 == '0);
      sign1_q <= sign1_c;
      sign2_q <= sign2_c;
      if (start_mul) begin
        mcand_q <= abs1_c;
        prod_q  <= {WIDTH'(0), abs2_c};
      end
    end else if (step) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (mul_q) prod_q <= {mul_sum_c, prod_q[WIDTH-1:1]};
    end
  end

  ex_div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_div),
    .step_i    (step && !mul_q),
    .dividend_i(abs1_c),
    .divisor_i (abs2_c),
    .quot_o    (quot_c),
    .rem_o     (rem_c)
  );

  assign prod_fix_c = (sign1_q ^ sign2_q) ? (~prod_q + PW'(1)) : prod_q;
  assign quot_fix_c = (sign1_q ^ sign2_q) ? (~quot_c + WIDTH'(1)) : quot_c;
  assign rem_fix_c  = sign1_q ? (~rem_c + WIDTH'(1)) : rem_c;

  // On divide-by-zero the core never steps, so its quotient still holds |dividend|.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done) begin
      if (mul_q) begin
        hi_q <= prod_fix_c[PW-1:WIDTH];
        lo_q <= prod_fix_c[WIDTH-1:0];
      end else if (dz_q) begin
        hi_q <= sign1_q ? (~quot_c + WIDTH'(1)) : quot_c;
        lo_q <= '1;
      end else begin
        hi_q <= rem_fix_c;
        lo_q <= quot_fix_c;
      end
    end else begin
      if (mt_hi) hi_q <= operand_1;
      if (mt_lo) lo_q <= operand_1;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed + randomised scoreboard bench for the EX-stage multiply/divide unit.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, en, flush;
  logic [5:0]  funct;
  logic [31:0] op1, op2;
  logic        stall_req;
  logic [31:0] result, hi, lo;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  stall;
  } exp_t;

  exp_t sbq[$];

  ex_muldiv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .funct    (funct),
    .operand_1(op1),
    .operand_2(op2),
    .flush    (flush),
    .stall_req(stall_req),
    .result   (result),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results from native 64-bit arithmetic.
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output exp_t e);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e  = '0;
    e.stall = 8'd33;
    case (f)
      FUNCT_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      FUNCT_MULT: begin
        p = 64'(sa * sb);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      FUNCT_DIVU, FUNCT_DIV: begin
        if (b == 32'h0) begin
          e.hi = a;
          e.lo = 32'hFFFF_FFFF;
          e.stall = 8'd1;
        end else if (f == FUNCT_DIVU) begin
          e.hi = a % b;
          e.lo = a / b;
        end else begin
          e.hi = 32'(sa % sb);
          e.lo = 32'(sa / sb);
        end
      end
      default: e = '0;
    endcase
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input logic [7:0] s);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.stall = s;
    sbq.push_back(e);
  endtask

  // Issue one mul/div, count stall cycles, let DONE retire, then score against the queue head.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b);
    exp_t e;
    int cyc;
    @(posedge clk); #1;
    en = 1'b1; funct = f; op1 = a; op2 = b;
    #1;
    cyc = 0;
    while (stall_req === 1'b1 && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    en = 1'b0; funct = '0;
    #1;
    e = sbq.pop_front();
    chk({tag, ".stall_cycles"}, 32'(cyc), 32'(e.stall));
    chk({tag, ".hi"}, hi, e.hi);
    chk({tag, ".lo"}, lo, e.lo);
    chk({tag, ".idle_after"}, 32'(stall_req), 32'h0);
  endtask

  task automatic one_cycle(input logic [5:0] f, input logic [31:0] a);
    @(posedge clk); #1;
    en = 1'b1; funct = f; op1 = a;
    #1;
  endtask

  initial begin
    exp_t e;
    logic [5:0] fsel [4];
    logic [5:0] f;
    logic [31:0] ra, rb;
    fsel[0] = FUNCT_MULT; fsel[1] = FUNCT_MULTU; fsel[2] = FUNCT_DIV; fsel[3] = FUNCT_DIVU;

    rst_n = 1'b0; en = 1'b0; flush = 1'b0; funct = '0; op1 = '0; op2 = '0;
    #12;
    chk("reset.hi", hi, 32'h0);
    chk("reset.lo", lo, 32'h0);
    chk("reset.stall", 32'(stall_req), 32'h0);
    chk("reset.result", result, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    push(32'hFFFF_FFFE, 32'h0000_0001, 8'd33);
    run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(32'hFFFF_FFFF, 32'hFFFF_FFEB, 8'd33);
    run_op("mult_neg", FUNCT_MULT, 32'hFFFF_FFFD, 32'd7);

    one_cycle(FUNCT_MFLO, 32'h0);
    chk("mflo.result", result, 32'hFFFF_FFEB);
    chk("mflo.stall", 32'(stall_req), 32'h0);

    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 8'd33);
    run_op("div_neg", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    push(32'd1, 32'd3, 8'd33);
    run_op("divu_7_2", FUNCT_DIVU, 32'd7, 32'd2);
    push(32'd5, 32'hFFFF_FFFF, 8'd1);
    run_op("divu_zero", FUNCT_DIVU, 32'd5, 32'd0);
    push(32'hFFFF_FFF9, 32'hFFFF_FFFF, 8'd1);
    run_op("div_zero_neg", FUNCT_DIV, 32'hFFFF_FFF9, 32'd0);
    push(32'h0, 32'h8000_0000, 8'd33);
    run_op("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

    one_cycle(FUNCT_MTHI, 32'h1234);
    chk("mthi.stall", 32'(stall_req), 32'h0);
    one_cycle(FUNCT_MTLO, 32'h5555);
    chk("mtlo.stall", 32'(stall_req), 32'h0);
    one_cycle(FUNCT_MFHI, 32'h0);
    chk("mfhi.result", result, 32'h1234);
    chk("mfhi.stall", 32'(stall_req), 32'h0);

    @(posedge clk); #1;
    flush = 1'b1; en = 1'b1; funct = FUNCT_MTHI; op1 = 32'hDEAD;
    @(posedge clk); #1;
    flush = 1'b0; funct = FUNCT_MFHI;
    #1;
    chk("flush_mthi.result", result, 32'h1234);

    // Flush a divide in its tenth iteration cycle.
    @(posedge clk); #1;
    en = 1'b1; funct = FUNCT_DIV; op1 = 32'd100; op2 = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    chk("flush.stall_in_flush", 32'(stall_req), 32'h0);
    @(posedge clk); #1;
    flush = 1'b0; en = 1'b0; funct = '0;
    #1;
    chk("flush.stall_after", 32'(stall_req), 32'h0);
    chk("flush.hi", hi, 32'h1234);
    chk("flush.lo", lo, 32'h5555);
    one_cycle(FUNCT_MFLO, 32'h0);
    chk("flush.mflo", result, 32'h5555);
    chk("flush.mflo_stall", 32'(stall_req), 32'h0);

    for (int i = 0; i < 8; i++) begin
      f  = fsel[$urandom_range(0, 3)];
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      model(f, ra, rb, e);
      sbq.push_back(e);
      run_op($sformatf("rand%0d", i), f, ra, rb);
    end

    push(32'h0, 32'd15, 8'd33);
    run_op("mult_pre_reset", FUNCT_MULT, 32'd3, 32'd5);
    @(posedge clk); #1;
    en = 1'b1; funct = FUNCT_MULT; op1 = 32'd9; op2 = 32'd9;
    repeat (5) @(posedge clk);
    #1;
    en = 1'b0; funct = '0;
    rst_n = 1'b0;
    #1;
    chk("midreset.hi", hi, 32'h0);
    chk("midreset.lo", lo, 32'h0);
    chk("midreset.stall", 32'(stall_req), 32'h0);
    chk("midreset.result", result, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    push(32'h0, 32'd42, 8'd33);
    run_op("multu_post_reset", FUNCT_MULTU, 32'd6, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
